ex_stage: RTL and testbench

- Execute stage, downstream end of the decode-to-execute interface.
- Consumes the decoded bundle (aluop, alusel, reg1, reg2, wd, wreg) each cycle and computes logic, shift and move results.
- Drives same-cycle forwarding back to decode and a registered EX/MEM result to the memory stage.
- Owns the architectural HI/LO registers, a one-deep pending HI/LO write, and HI/LO forwarding for MFHI/MFLO.

---
 rtl/ex_stage_pkg.sv | 63 ++++++
 rtl/ex_stage_hilo_reg.sv | 72 +++++++
 rtl/ex_stage.sv | 162 ++++++++++++++++
 tb/tb_ex_stage.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// -----------------------------------------------------------------------------
// ex_stage_pkg
//   Shared definitions for the execute stage and its HI/LO sub-block:
//   default bus widths, the aluop / alusel encodings produced by decode,
//   the HI/LO select type and a helper that recognises legal aluop codes.
// -----------------------------------------------------------------------------
package ex_stage_pkg;

    // Default bus widths
    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int ALUOP_W_DEF  = 8;
    localparam int ALUSEL_W_DEF = 3;

    // Shift amount is always taken from the low five bits of reg1
    localparam int SHAMT_W = 5;

    localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;

    // aluop encodings
    localparam logic [ALUOP_W_DEF-1:0] ALUOP_NOP  = 8'h00;
    localparam logic [ALUOP_W_DEF-1:0] ALUOP_AND  = 8'h24;
    localparam logic [ALUOP_W_DEF-1:0] ALUOP_OR   = 8'h25;
    localparam logic [ALUOP_W_DEF-1:0] ALUOP_XOR  = 8'h26;
    localparam logic [ALUOP_W_DEF-1:0] ALUOP_NOR  = 8'h27;
    localparam logic [ALUOP_W_DEF-1:0] ALUOP_SLL  = 8'h7C;
    localparam logic [ALUOP_W_DEF-1:0] ALUOP_SRL  = 8'h02;
    localparam logic [ALUOP_W_DEF-1:0] ALUOP_SRA  = 8'h03;
    localparam logic [ALUOP_W_DEF-1:0] ALUOP_MOVZ = 8'h0A;
    localparam logic [ALUOP_W_DEF-1:0] ALUOP_MOVN = 8'h0B;
    localparam logic [ALUOP_W_DEF-1:0] ALUOP_MFHI = 8'h10;
    localparam logic [ALUOP_W_DEF-1:0] ALUOP_MTHI = 8'h11;
    localparam logic [ALUOP_W_DEF-1:0] ALUOP_MFLO = 8'h12;
    localparam logic [ALUOP_W_DEF-1:0] ALUOP_MTLO = 8'h13;

    // alusel encodings (result class)
    localparam logic [ALUSEL_W_DEF-1:0] ALUSEL_NOP   = 3'b000;
    localparam logic [ALUSEL_W_DEF-1:0] ALUSEL_LOGIC = 3'b001;
    localparam logic [ALUSEL_W_DEF-1:0] ALUSEL_SHIFT = 3'b010;
    localparam logic [ALUSEL_W_DEF-1:0] ALUSEL_MOVE  = 3'b011;

    // Which of the two special registers a pending write targets
    typedef enum logic {
        HILO_SEL_HI = 1'b0,
        HILO_SEL_LO = 1'b1
    } hilo_sel_e;

    // True for every aluop this stage implements; anything else is treated
    // as an illegal instruction and must not write the register file.
    function automatic logic is_known_aluop(input logic [ALUOP_W_DEF-1:0] op);
        logic known;
        known = 1'b0;
        case (op)
            ALUOP_NOP, ALUOP_AND, ALUOP_OR, ALUOP_XOR, ALUOP_NOR,
            ALUOP_SLL, ALUOP_SRL, ALUOP_SRA,
            ALUOP_MOVZ, ALUOP_MOVN,
            ALUOP_MFHI, ALUOP_MTHI, ALUOP_MFLO, ALUOP_MTLO: known = 1'b1;
            default:                                        known = 1'b0;
        endcase
        return known;
    endfunction

endpackage : ex_stage_pkg

// File: rtl/ex_stage_hilo_reg.sv
// -----------------------------------------------------------------------------
// hilo_reg
//   Architectural HI/LO registers with a one-deep pending write in front of
//   them. An MTHI/MTLO first lands in the pending slot; the slot is committed
//   to HI or LO on the next unstalled edge. The effective outputs forward the
//   pending data to MFHI/MFLO so a read right behind a write sees new data.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset; clears HI, LO and pending slot
//   stall    in   freezes commit and pending load
//   wr_en    in   current op is MTHI/MTLO (load pending slot)
//   wr_sel   in   target of the new pending write
//   wr_data  in   data of the new pending write
//   hi, lo   out  architectural HI / LO
//   hi_eff   out  HI as seen by MFHI (pending data if it targets HI)
//   lo_eff   out  LO as seen by MFLO (pending data if it targets LO)
// -----------------------------------------------------------------------------
module hilo_reg
    import ex_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              wr_en,
    input  hilo_sel_e         wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi_eff,
    output logic [DATA_W-1:0] lo_eff
);

    logic              pend_valid;
    hilo_sel_e         pend_sel;
    logic [DATA_W-1:0] pend_data;

    // NOTE: state registers use non-blocking assignments so every flop in the
    // block samples values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the pending slot is cleared along with HI/LO; a held MTHI
            // surviving reset would silently commit into the cleared register.
            hi         <= '0;
            lo         <= '0;
            pend_valid <= 1'b0;
            pend_sel   <= HILO_SEL_HI;
            pend_data  <= '0;
        end else if (!stall) begin
            // Retire the older write and accept the newer one on the same
            // edge, so MTHI followed by MTLO flows without a bubble.
            if (pend_valid) begin
                if (pend_sel == HILO_SEL_HI) begin
                    hi <= pend_data;
                end else begin
                    lo <= pend_data;
                end
            end
            pend_valid <= wr_en;
            if (wr_en) begin
                pend_sel  <= wr_sel;
                pend_data <= wr_data;
            end
        end
    end

    assign hi_eff = (pend_valid && (pend_sel == HILO_SEL_HI)) ? pend_data : hi;
    assign lo_eff = (pend_valid && (pend_sel == HILO_SEL_LO)) ? pend_data : lo;

endmodule : hilo_reg

// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage
//   Execute stage at the receiving end of the decode-to-execute interface.
//   Computes logic, shift and move results from the decoded bundle, forwards
//   the result combinationally to decode, registers it into EX/MEM, and owns
//   the HI/LO registers (via hilo_reg).
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   stall_i             holds EX/MEM and freezes HI/LO commit
//   aluop_i, alusel_i   operation and result class from decode
//   reg1_i, reg2_i      operands (reg1[4:0] is the shift amount; reg2 is the
//                       shifted value and the MOVN/MOVZ condition)
//   wd_i, wreg_i        destination register and its write enable
//   ex_wreg_o/ex_wd_o/ex_wdata_o     same-cycle forward to decode
//   mem_wreg_o/mem_wd_o/mem_wdata_o  registered result to MEM
//   hi_o, lo_o          architectural HI / LO
// -----------------------------------------------------------------------------
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ALUOP_W  = ALUOP_W_DEF,
    parameter int ALUSEL_W = ALUSEL_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_i,
    input  logic [ALUOP_W-1:0]  aluop_i,
    input  logic [ALUSEL_W-1:0] alusel_i,
    input  logic [DATA_W-1:0]   reg1_i,
    input  logic [DATA_W-1:0]   reg2_i,
    input  logic [ADDR_W-1:0]   wd_i,
    input  logic                wreg_i,
    output logic                ex_wreg_o,
    output logic [ADDR_W-1:0]   ex_wd_o,
    output logic [DATA_W-1:0]   ex_wdata_o,
    output logic                mem_wreg_o,
    output logic [ADDR_W-1:0]   mem_wd_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o
);

    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  hi_eff;
    logic [DATA_W-1:0]  lo_eff;
    logic               hilo_wr_en;
    hilo_sel_e          hilo_wr_sel;
    logic [DATA_W-1:0]  result;
    logic               wreg;

    assign shamt = reg1_i[SHAMT_W-1:0];

    // -------------------------------------------------------------------------
    // Result mux: alusel picks the class, aluop picks the op within it. A
    // class/op pair that does not belong together yields zero.
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default before the case
    // statements; a path that skips an assignment would otherwise infer a latch.
    always_comb begin
        result = DATA_W'(ZERO_WORD);
        case (alusel_i)
            ALUSEL_LOGIC: begin
                case (aluop_i)
                    ALUOP_AND: result = reg1_i & reg2_i;
                    ALUOP_OR:  result = reg1_i | reg2_i;
                    ALUOP_XOR: result = reg1_i ^ reg2_i;
                    ALUOP_NOR: result = ~(reg1_i | reg2_i);
                    default:   result = DATA_W'(ZERO_WORD);
                endcase
            end
            ALUSEL_SHIFT: begin
                case (aluop_i)
                    ALUOP_SLL: result = reg2_i << shamt;
                    ALUOP_SRL: result = reg2_i >> shamt;
                    ALUOP_SRA: result = $signed(reg2_i) >>> shamt;
                    default:   result = DATA_W'(ZERO_WORD);
                endcase
            end
            ALUSEL_MOVE: begin
                case (aluop_i)
                    ALUOP_MOVZ, ALUOP_MOVN: result = reg1_i;
                    ALUOP_MFHI:             result = hi_eff;
                    ALUOP_MFLO:             result = lo_eff;
                    default:                result = DATA_W'(ZERO_WORD);
                endcase
            end
            default: result = DATA_W'(ZERO_WORD);
        endcase
    end

    // -------------------------------------------------------------------------
    // Write-enable and HI/LO write decode. These follow the aluop alone: MOVN
    // and MOVZ override decode's wreg with their condition on reg2, MTHI/MTLO
    // never write the register file, and an unknown aluop is squashed.
    // -------------------------------------------------------------------------
    always_comb begin
        wreg        = wreg_i;
        hilo_wr_en  = 1'b0;
        hilo_wr_sel = HILO_SEL_HI;
        if (!is_known_aluop(aluop_i)) begin
            wreg = 1'b0;
        end else begin
            case (aluop_i)
                ALUOP_MOVN: wreg = |reg2_i;
                ALUOP_MOVZ: wreg = ~|reg2_i;
                ALUOP_MTHI: begin
                    wreg        = 1'b0;
                    hilo_wr_en  = 1'b1;
                    hilo_wr_sel = HILO_SEL_HI;
                end
                ALUOP_MTLO: begin
                    wreg        = 1'b0;
                    hilo_wr_en  = 1'b1;
                    hilo_wr_sel = HILO_SEL_LO;
                end
                default: wreg = wreg_i;
            endcase
        end
    end

    // Same-cycle forward to decode; stays live during a stall.
    assign ex_wreg_o  = wreg;
    assign ex_wd_o    = wd_i;
    assign ex_wdata_o = result;

    // -------------------------------------------------------------------------
    // EX/MEM pipeline register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wreg_o  <= 1'b0;
            mem_wd_o    <= '0;
            mem_wdata_o <= '0;
        end else if (!stall_i) begin
            mem_wreg_o  <= wreg;
            mem_wd_o    <= wd_i;
            mem_wdata_o <= result;
        end
    end

    // -------------------------------------------------------------------------
    // HI/LO registers with pending write and MFHI/MFLO forwarding
    // -------------------------------------------------------------------------
    hilo_reg #(
        .DATA_W (DATA_W)
    ) u_hilo_reg (
        .clk     (clk),
        .rst     (rst),
        .stall   (stall_i),
        .wr_en   (hilo_wr_en),
        .wr_sel  (hilo_wr_sel),
        .wr_data (reg1_i),
        .hi      (hi_o),
        .lo      (lo_o),
        .hi_eff  (hi_eff),
        .lo_eff  (lo_eff)
    );

endmodule : ex_stage

// File: tb/tb_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_ex_stage
//   Self-checking bench for ex_stage: a table of single-cycle vectors checked
//   on the forwarding outputs and, one edge later, on EX/MEM; followed by
//   hand-written sequences for HI/LO forwarding, stall and reset-mid-stall.
// -----------------------------------------------------------------------------
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        ex_wreg_o;
    logic [4:0]  ex_wd_o;
    logic [31:0] ex_wdata_o;
    logic        mem_wreg_o;
    logic [4:0]  mem_wd_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_checks = 0;
    int n_fail   = 0;

    ex_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (stall_i),
        .aluop_i     (aluop_i),
        .alusel_i    (alusel_i),
        .reg1_i      (reg1_i),
        .reg2_i      (reg2_i),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .ex_wreg_o   (ex_wreg_o),
        .ex_wd_o     (ex_wd_o),
        .ex_wdata_o  (ex_wdata_o),
        .mem_wreg_o  (mem_wreg_o),
        .mem_wd_o    (mem_wd_o),
        .mem_wdata_o (mem_wdata_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [4:0]  wd;
        logic        wreg;
        logic        exp_wreg;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [4:0] wd, input logic wr);
        aluop_i  = op;
        alusel_i = sel;
        reg1_i   = r1;
        reg2_i   = r2;
        wd_i     = wd;
        wreg_i   = wr;
    endtask

    // Advance one rising edge and settle outputs away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{ALUOP_OR,   ALUSEL_LOGIC, 32'h0000_FF00, 32'h0F0F_0000, 5'd5,  1'b1, 1'b1, 32'h0F0F_FF00};
        vecs[1]  = '{ALUOP_AND,  ALUSEL_LOGIC, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd6,  1'b1, 1'b1, 32'h0F00_0F00};
        vecs[2]  = '{ALUOP_XOR,  ALUSEL_LOGIC, 32'hFFFF_0000, 32'h00FF_FF00, 5'd7,  1'b1, 1'b1, 32'hFF00_FF00};
        vecs[3]  = '{ALUOP_NOR,  ALUSEL_LOGIC, 32'h0F0F_0F0F, 32'h3030_3030, 5'd8,  1'b1, 1'b1, 32'hC0C0_C0C0};
        vecs[4]  = '{ALUOP_SRA,  ALUSEL_SHIFT, 32'd4,         32'h8000_0010, 5'd10, 1'b1, 1'b1, 32'hF800_0001};
        vecs[5]  = '{ALUOP_SRL,  ALUSEL_SHIFT, 32'd4,         32'h8000_0010, 5'd11, 1'b1, 1'b1, 32'h0800_0001};
        vecs[6]  = '{ALUOP_SLL,  ALUSEL_SHIFT, 32'd31,        32'h0000_0001, 5'd12, 1'b1, 1'b1, 32'h8000_0000};
        vecs[7]  = '{ALUOP_SRA,  ALUSEL_SHIFT, 32'h0000_0020, 32'h8000_0010, 5'd13, 1'b1, 1'b1, 32'h8000_0010};
        vecs[8]  = '{ALUOP_SRA,  ALUSEL_SHIFT, 32'd31,        32'h8000_0000, 5'd14, 1'b1, 1'b1, 32'hFFFF_FFFF};
        vecs[9]  = '{ALUOP_MOVN, ALUSEL_MOVE,  32'h1111_2222, 32'h0000_0000, 5'd15, 1'b1, 1'b0, 32'h1111_2222};
        vecs[10] = '{ALUOP_MOVN, ALUSEL_MOVE,  32'h3333_4444, 32'h0000_0001, 5'd16, 1'b0, 1'b1, 32'h3333_4444};
        vecs[11] = '{ALUOP_MOVZ, ALUSEL_MOVE,  32'hDEAD_BEEF, 32'h0000_0000, 5'd17, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[12] = '{ALUOP_MOVZ, ALUSEL_MOVE,  32'h0000_0001, 32'h8000_0000, 5'd18, 1'b1, 1'b0, 32'h0000_0001};
        vecs[13] = '{ALUOP_MFHI, ALUSEL_MOVE,  32'h5555_5555, 32'h6666_6666, 5'd19, 1'b1, 1'b1, 32'h0000_0000};
        vecs[14] = '{ALUOP_NOP,  ALUSEL_NOP,   32'h1234_0000, 32'h0000_4321, 5'd20, 1'b1, 1'b1, 32'h0000_0000};
        vecs[15] = '{8'hFF,      ALUSEL_LOGIC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd21, 1'b1, 1'b0, 32'h0000_0000};
        vecs[16] = '{ALUOP_AND,  3'b111,       32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd22, 1'b1, 1'b1, 32'h0000_0000};
        vecs[17] = '{ALUOP_SLL,  ALUSEL_SHIFT, 32'd8,         32'h0000_00FF, 5'd9,  1'b1, 1'b1, 32'h0000_FF00};

        // ---------------- reset ----------------
        rst     = 1'b1;
        stall_i = 1'b0;
        drive(ALUOP_NOP, ALUSEL_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
        tick();
        tick();
        check("reset mem_wreg",  {31'b0, mem_wreg_o}, 32'h0);
        check("reset mem_wd",    {27'b0, mem_wd_o},   32'h0);
        check("reset mem_wdata", mem_wdata_o,         32'h0);
        check("reset hi",        hi_o,                32'h0);
        check("reset lo",        lo_o,                32'h0);
        rst = 1'b0;

        // ---------------- table vectors ----------------
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].aluop, vecs[i].alusel, vecs[i].reg1, vecs[i].reg2,
                  vecs[i].wd, vecs[i].wreg);
            #1;
            check($sformatf("vec%0d ex_wreg", i),  {31'b0, ex_wreg_o}, {31'b0, vecs[i].exp_wreg});
            check($sformatf("vec%0d ex_wd", i),    {27'b0, ex_wd_o},   {27'b0, vecs[i].wd});
            check($sformatf("vec%0d ex_wdata", i), ex_wdata_o,         vecs[i].exp_wdata);
            tick();
            check($sformatf("vec%0d mem_wreg", i),  {31'b0, mem_wreg_o}, {31'b0, vecs[i].exp_wreg});
            check($sformatf("vec%0d mem_wd", i),    {27'b0, mem_wd_o},   {27'b0, vecs[i].wd});
            check($sformatf("vec%0d mem_wdata", i), mem_wdata_o,         vecs[i].exp_wdata);
        end

        // ---------------- MTLO under a 3-cycle stall ----------------
        // EX/MEM holds the last table vector (SLL -> wreg 1, wd 9, 0000_FF00)
        stall_i = 1'b1;
        drive(ALUOP_MTLO, ALUSEL_MOVE, 32'hA5A5_A5A5, 32'h0, 5'd0, 1'b0);
        #1;
        check("stall ex_wreg live", {31'b0, ex_wreg_o}, 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("stall%0d lo", c),        lo_o,                32'h0);
            check($sformatf("stall%0d mem_wreg", c),  {31'b0, mem_wreg_o}, 32'h1);
            check($sformatf("stall%0d mem_wd", c),    {27'b0, mem_wd_o},   32'd9);
            check($sformatf("stall%0d mem_wdata", c), mem_wdata_o,         32'h0000_FF00);
        end
        stall_i = 1'b0;
        tick();
        check("unstall load lo",        lo_o,                32'h0);
        check("unstall load mem_wreg",  {31'b0, mem_wreg_o}, 32'h0);
        check("unstall load mem_wdata", mem_wdata_o,         32'h0);
        drive(ALUOP_NOP, ALUSEL_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
        tick();
        check("unstall commit lo", lo_o, 32'hA5A5_A5A5);

        // ---------------- MTHI then MFHI ----------------
        drive(ALUOP_MTHI, ALUSEL_MOVE, 32'h1234_5678, 32'h0, 5'd0, 1'b0);
        #1;
        check("mthi ex_wreg", {31'b0, ex_wreg_o}, 32'h0);
        tick();
        drive(ALUOP_MFLO, ALUSEL_MOVE, 32'h0, 32'h0, 5'd2, 1'b1);
        #1;
        check("mflo ignores hi pending", ex_wdata_o, 32'hA5A5_A5A5);
        drive(ALUOP_MFHI, ALUSEL_MOVE, 32'h0, 32'h0, 5'd3, 1'b1);
        #1;
        check("mfhi fwd pending", ex_wdata_o, 32'h1234_5678);
        check("hi before commit", hi_o,       32'h0);
        tick();
        check("hi after commit",    hi_o,        32'h1234_5678);
        check("mfhi mem_wdata",     mem_wdata_o, 32'h1234_5678);
        check("mfhi mem_wd",        {27'b0, mem_wd_o}, 32'd3);

        // ---------------- MTHI then MTLO back to back ----------------
        drive(ALUOP_MTHI, ALUSEL_MOVE, 32'hAAAA_0000, 32'h0, 5'd0, 1'b0);
        tick();
        drive(ALUOP_MTLO, ALUSEL_MOVE, 32'h0000_BBBB, 32'h0, 5'd0, 1'b0);
        tick();
        check("b2b hi committed", hi_o, 32'hAAAA_0000);
        check("b2b lo unchanged", lo_o, 32'hA5A5_A5A5);
        drive(ALUOP_MFLO, ALUSEL_MOVE, 32'h0, 32'h0, 5'd4, 1'b1);
        #1;
        check("b2b mflo fwd", ex_wdata_o, 32'h0000_BBBB);
        tick();
        check("b2b lo committed", lo_o, 32'h0000_BBBB);

        // ---------------- reset during stall with pending MTHI ----------------
        drive(ALUOP_MTHI, ALUSEL_MOVE, 32'h5555_6666, 32'h0, 5'd0, 1'b0);
        tick();
        stall_i = 1'b1;
        drive(ALUOP_MFHI, ALUSEL_MOVE, 32'h0, 32'h0, 5'd4, 1'b1);
        #1;
        check("stall mfhi fwd", ex_wdata_o, 32'h5555_6666);
        tick();
        check("stall hi no commit", hi_o, 32'hAAAA_0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst-stall hi",        hi_o,                32'h0);
        check("rst-stall lo",        lo_o,                32'h0);
        check("rst-stall mem_wreg",  {31'b0, mem_wreg_o}, 32'h0);
        check("rst-stall mem_wdata", mem_wdata_o,         32'h0);
        stall_i = 1'b0;
        #1;
        check("post-rst mfhi", ex_wdata_o, 32'h0);
        tick();
        check("post-rst hi no ghost", hi_o,        32'h0);
        check("post-rst mem_wreg",    {31'b0, mem_wreg_o}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ex_stage
